// File: rtl/phase_sequencer.sv
// Multi-phase timing sequencer: steps through NUM_PH phases of programmable length,
// driving the demux selector, per-phase end strobe and register-bank write enable.
//
// state | meaning
// IDLE  | waiting for i_start, outputs quiet
// RUN   | stepping phases, o_busy high
// DONE  | one-cycle o_done pulse after a single-shot round
module phase_sequencer #(
  parameter int CNT_W    = 4,
  parameter int NUM_PH   = 3,
  parameter int SEL_W    = 2,
  parameter int WR_PHASE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_stall,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_busy,
  output logic [SEL_W-1:0] o_phase_sel,
  output logic             o_phase_strobe,
  output logic             o_e_write_br,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [SEL_W-1:0] WR_SEL   = SEL_W'(WR_PHASE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [SEL_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] period_in;
  logic             last;

  // A programmed period of 0 behaves as a one-cycle phase.
  assign period_in = (i_period == '0) ? ONE : i_period;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= '0;
      period_q <= ONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    period_d       = period_q;
    last           = 1'b0;
    o_busy         = 1'b0;
    o_phase_sel    = '0;
    o_phase_strobe = 1'b0;
    o_e_write_br   = 1'b0;
    o_done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          phase_d  = '0;
          period_d = period_in;
        end
      end
      S_RUN: begin
        o_busy         = 1'b1;
        o_phase_sel    = phase_q;
        last           = (cnt_q == period_q - ONE) && !i_stall;
        o_phase_strobe = last;
        o_e_write_br   = last && (phase_q == WR_SEL);
        if (!i_stall) begin
          if (!last) begin
            cnt_d = cnt_q + ONE;
          end else if (phase_q != LAST_SEL) begin
            cnt_d   = '0;
            phase_d = phase_q + SEL_W'(1);
          end else if (i_mode) begin
            // Round wrap in continuous mode picks up a fresh period.
            cnt_d    = '0;
            phase_d  = '0;
            period_d = period_in;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
            phase_d = '0;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus pushes expected busy/done cycles,
// a negedge monitor pops and compares them and checks that idle cycles stay quiet.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_mode = 1'b0;
  logic       i_stall = 1'b0;
  logic [3:0] i_period = 4'd3;
  logic       o_busy;
  logic [1:0] o_phase_sel;
  logic       o_phase_strobe;
  logic       o_e_write_br;
  logic       o_done;

  int n_vec = 0;
  int n_err = 0;

  // {busy, sel[1:0], strobe, write, done}
  logic [5:0] exp_q[$];

  phase_sequencer dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
    .i_mode(i_mode),
    .i_stall(i_stall),
    .i_period(i_period),
    .o_busy(o_busy),
    .o_phase_sel(o_phase_sel),
    .o_phase_strobe(o_phase_strobe),
    .o_e_write_br(o_e_write_br),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic push(input bit busy, input int sel, input bit stb, input bit wr, input bit done);
    logic [1:0] s;
    s = sel[1:0];
    exp_q.push_back({busy, s, stb, wr, done});
  endtask

  // Expected cycles of nrounds unstalled rounds at the given period, optionally with the done pulse.
  task automatic push_run(input int per, input int nrounds, input bit with_done);
    for (int r = 0; r < nrounds; r++)
      for (int ph = 0; ph < 3; ph++)
        for (int c = 0; c < per; c++)
          push(1'b1, ph, c == per - 1, (c == per - 1) && (ph == 2), 1'b0);
    if (with_done) push(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at busy cycle 1 (just after the edge that sampled i_start).
  task automatic launch();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [5:0] act;
    logic [5:0] e;
    act = {o_busy, o_phase_sel, o_phase_strobe, o_e_write_br, o_done};
    if (!reset) begin
      n_vec++;
      if (o_busy || o_done) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output t=%0t got=%b expected nothing", $time, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t got=%b expected=%b (busy,sel,stb,wr,done)", $time, act, e);
          end
        end
      end else if (act !== 6'b0) begin
        n_err++;
        $display("FAIL idle_quiet t=%0t got=%b expected=000000", $time, act);
      end
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1: period 3 single-shot
    i_period = 4'd3;
    push_run(3, 1, 1'b1);
    tick(1);
    launch();
    tick(11);

    // 2: period 0 behaves as 1
    i_period = 4'd0;
    push_run(1, 1, 1'b1);
    launch();
    tick(5);

    // 3: continuous period 2, drop mode in round 2 -> exactly two rounds
    i_period = 4'd2;
    i_mode = 1'b1;
    push_run(2, 2, 1'b1);
    launch();
    tick(7);
    i_mode = 1'b0;
    tick(7);

    // 4: stall two cycles at phase 1, cnt 2 -> 11 busy cycles
    i_period = 4'd3;
    push(1, 0, 0, 0, 0); push(1, 0, 0, 0, 0); push(1, 0, 1, 0, 0);
    push(1, 1, 0, 0, 0); push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 0); push(1, 1, 0, 0, 0);
    push(1, 1, 1, 0, 0);
    push(1, 2, 0, 0, 0); push(1, 2, 0, 0, 0); push(1, 2, 1, 1, 0);
    push(0, 0, 0, 0, 1);
    launch();
    tick(5);
    i_stall = 1'b1;
    tick(2);
    i_stall = 1'b0;
    tick(6);

    // 5: reset during phase 1, then a full run
    push(1, 0, 0, 0, 0); push(1, 0, 0, 0, 0); push(1, 0, 1, 0, 0);
    launch();
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    push_run(3, 1, 1'b1);
    launch();
    tick(11);

    // 6: start held, period changed mid-run; the follow-up run uses period 5
    i_period = 4'd3;
    push_run(3, 1, 1'b1);
    push_run(5, 1, 1'b1);
    i_start = 1'b1;
    tick(1);
    tick(3);
    i_period = 4'd5;
    tick(9);
    i_start = 1'b0;
    tick(17);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected got=%0d pending expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
